// File: rtl/cpu_mem_responder.sv
// Responder for the core's fetch and data request ports. Both requesters share one
// synchronous RAM. Data has fixed priority, and every grant returns one ready pulse.
module cpu_mem_responder #(
   parameter int          RAM_AW      = 20,
   parameter int          RAM_LATENCY = 1,
   parameter logic [63:0] ADDR_BASE   = 64'h0000_0000_8000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   input  logic [63:0]       if_addr,
   input  logic [1:0]        if_size,
   output logic              if_ready,
   output logic [1:0]        if_resp,
   output logic [63:0]       if_data_read,
   input  logic              mem_valid,
   input  logic [1:0]        mem_req,
   input  logic [63:0]       mem_addr,
   input  logic [1:0]        mem_size,
   input  logic [63:0]       mem_data_write,
   output logic              mem_ready,
   output logic [1:0]        mem_resp,
   output logic [63:0]       mem_data_read,
   output logic              ram_en,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [7:0]        ram_wstrb,
   output logic [63:0]       ram_wdata,
   input  logic [63:0]       ram_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   localparam logic [2:0] LAT = 3'(RAM_LATENCY);

   state_e      state_q, state_d;
   logic        gnt_mem_q, gnt_mem_d;
   logic [63:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        we_q, we_d;
   logic [63:0] wdata_q, wdata_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [1:0]  if_resp_q, if_resp_d, mem_resp_q, mem_resp_d;
   logic [63:0] if_data_q, if_data_d, mem_data_q, mem_data_d;

   logic [63:0] req_addr, req_off;
   logic [1:0]  req_size;
   logic        req_oor, req_mis;
   logic [1:0]  req_err;
   logic [7:0]  strb;

   always_comb begin
      req_addr = mem_valid ? mem_addr : if_addr;
      req_size = mem_valid ? mem_size : if_size;
      req_off  = req_addr - ADDR_BASE;
      req_oor  = (req_off >> (RAM_AW + 3)) != 64'd0;
      case (req_size)
         2'b00:   req_mis = 1'b0;
         2'b01:   req_mis = req_addr[0];
         2'b10:   req_mis = |req_addr[1:0];
         default: req_mis = |req_addr[2:0];
      endcase
      // Range is checked first, so a misaligned address that is also out of range reports 11.
      req_err = req_oor ? 2'b11 : (req_mis ? 2'b10 : 2'b00);
   end

   always_comb begin
      state_d    = state_q;
      gnt_mem_d  = gnt_mem_q;
      addr_d     = addr_q;
      size_d     = size_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      if_resp_d  = if_resp_q;
      if_data_d  = if_data_q;
      mem_resp_d = mem_resp_q;
      mem_data_d = mem_data_q;
      case (state_q)
         IDLE: begin
            if (mem_valid || if_valid) begin
               gnt_mem_d = mem_valid;
               addr_d    = req_addr;
               size_d    = req_size;
               we_d      = mem_valid && (mem_req == 2'b01);
               wdata_d   = mem_data_write;
               if (req_err != 2'b00) begin
                  state_d = RESP;
                  if (mem_valid) begin
                     mem_resp_d = req_err;
                     mem_data_d = 64'd0;
                  end else begin
                     if_resp_d = req_err;
                     if_data_d = 64'd0;
                  end
               end else begin
                  state_d = ACCESS;
                  cnt_d   = LAT;
               end
            end
         end
         ACCESS: begin
            if (cnt_q == 3'd0) begin
               state_d = RESP;
               if (gnt_mem_q) begin
                  mem_resp_d = 2'b00;
                  mem_data_d = we_q ? 64'd0 : ram_rdata;
               end else begin
                  if_resp_d = 2'b00;
                  if_data_d = ram_rdata;
               end
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         gnt_mem_q  <= 1'b0;
         addr_q     <= 64'd0;
         size_q     <= 2'b00;
         we_q       <= 1'b0;
         wdata_q    <= 64'd0;
         cnt_q      <= 3'd0;
         if_resp_q  <= 2'b00;
         if_data_q  <= 64'd0;
         mem_resp_q <= 2'b00;
         mem_data_q <= 64'd0;
      end else begin
         state_q    <= state_d;
         gnt_mem_q  <= gnt_mem_d;
         addr_q     <= addr_d;
         size_q     <= size_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         if_resp_q  <= if_resp_d;
         if_data_q  <= if_data_d;
         mem_resp_q <= mem_resp_d;
         mem_data_q <= mem_data_d;
      end
   end

   // The counter still holds its load value only during the first ACCESS cycle.
   always_comb begin
      case (size_q)
         2'b00:   strb = 8'h01 << addr_q[2:0];
         2'b01:   strb = 8'h03 << addr_q[2:0];
         2'b10:   strb = 8'h0F << addr_q[2:0];
         default: strb = 8'hFF;
      endcase
      ram_en    = (state_q == ACCESS) && (cnt_q == LAT);
      ram_we    = ram_en && we_q;
      ram_addr  = ram_en ? (addr_q[RAM_AW+2:3] - ADDR_BASE[RAM_AW+2:3]) : '0;
      ram_wstrb = ram_we ? strb : 8'h00;
      ram_wdata = ram_we ? (wdata_q << {addr_q[2:0], 3'b000}) : 64'd0;
   end

   assign if_ready      = (state_q == RESP) && !gnt_mem_q;
   assign mem_ready     = (state_q == RESP) && gnt_mem_q;
   assign if_resp       = if_resp_q;
   assign if_data_read  = if_data_q;
   assign mem_resp      = mem_resp_q;
   assign mem_data_read = mem_data_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: a byte-level reference memory predicts each response.
// A monitor checks ready timing, response fields, held outputs and RAM strobes.
module tb_cpu_mem_responder;

   localparam int          AW   = 10;
   localparam int          LAT  = 1;
   localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
   localparam longint      RSZ  = longint'(1) << (AW + 3);

   logic clk = 1'b0, rst = 1'b1;
   logic if_valid = 1'b0, mem_valid = 1'b0;
   logic [63:0] if_addr = '0, mem_addr = '0, mem_data_write = '0;
   logic [1:0]  if_size = '0, mem_size = '0, mem_req = '0;
   logic if_ready, mem_ready, ram_en, ram_we;
   logic [1:0] if_resp, mem_resp;
   logic [63:0] if_data_read, mem_data_read, ram_wdata, ram_rdata;
   logic [AW-1:0] ram_addr;
   logic [7:0] ram_wstrb;

   cpu_mem_responder #(.RAM_AW(AW), .RAM_LATENCY(LAT), .ADDR_BASE(BASE)) dut (
      .clk(clk), .rst(rst),
      .if_valid(if_valid), .if_addr(if_addr), .if_size(if_size),
      .if_ready(if_ready), .if_resp(if_resp), .if_data_read(if_data_read),
      .mem_valid(mem_valid), .mem_req(mem_req), .mem_addr(mem_addr), .mem_size(mem_size),
      .mem_data_write(mem_data_write), .mem_ready(mem_ready), .mem_resp(mem_resp),
      .mem_data_read(mem_data_read),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wstrb(ram_wstrb),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] init_dw(input longint idx);
      return {32'(idx) ^ 32'hA5C3_1E77, ~32'(idx * 7)};
   endfunction

   // Backend RAM seen by the DUT
   logic [63:0] bmem [longint];
   logic [63:0] dly [0:7];
   assign ram_rdata = dly[LAT-1];

   function automatic logic [63:0] bread(input longint idx);
      return bmem.exists(idx) ? bmem[idx] : init_dw(idx);
   endfunction

   always @(posedge clk) begin
      logic [63:0] t;
      for (int i = 7; i > 0; i--) dly[i] <= dly[i-1];
      dly[0] <= (ram_en && !ram_we) ? bread(longint'(ram_addr)) : {$urandom, $urandom};
      if (ram_en && ram_we) begin
         t = bread(longint'(ram_addr));
         for (int b = 0; b < 8; b++) if (ram_wstrb[b]) t[8*b +: 8] = ram_wdata[8*b +: 8];
         bmem[longint'(ram_addr)] = t;
      end
   end

   // Reference model: plain byte-addressed memory
   logic [7:0] rmem [longint];

   function automatic logic [7:0] ref_byte(input longint off);
      logic [63:0] d;
      if (rmem.exists(off)) return rmem[off];
      d = init_dw(off >> 3);
      return d[8*(off % 8) +: 8];
   endfunction

   function automatic logic [63:0] ref_dword(input longint off);
      logic [63:0] d;
      longint b0 = off - (off % 8);
      for (int i = 0; i < 8; i++) d[8*i +: 8] = ref_byte(b0 + i);
      return d;
   endfunction

   task automatic preload(input longint idx, input logic [63:0] v);
      bmem[idx] = v;
      for (int i = 0; i < 8; i++) rmem[idx*8 + i] = v[8*i +: 8];
   endtask

   typedef struct { logic [1:0] resp; logic [63:0] data; int due; } exp_t;
   typedef struct { int due; logic we; logic [63:0] addr; logic [7:0] strb; logic [63:0] wdata; } ram_t;
   exp_t exp_if[$], exp_mem[$];
   ram_t exp_ram[$];

   // Predicts one granted request. t0 is its grant cycle; done is its ready cycle.
   task automatic predict(input bit is_mem, input logic [63:0] addr, input logic [1:0] size,
                          input bit we, input logic [63:0] wd, input int t0, output int done);
      exp_t e;
      ram_t r;
      longint unsigned off = addr - BASE;
      int nb = 1 << size;
      if (off >= longint'(RSZ)) e.resp = 2'b11;
      else if ((addr % nb) != 0) e.resp = 2'b10;
      else e.resp = 2'b00;
      if (e.resp != 2'b00) begin
         e.data = 64'd0;
         e.due  = t0 + 1;
      end else begin
         e.due  = t0 + 2 + LAT;
         r.due  = t0 + 1;
         r.we   = we;
         r.addr = off / 8;
         r.strb = we ? 8'(((1 << nb) - 1) << (addr % 8)) : 8'h00;
         r.wdata = we ? (wd << (8 * (addr % 8))) : 64'd0;
         exp_ram.push_back(r);
         if (we) begin
            e.data = 64'd0;
            for (int i = 0; i < nb; i++) rmem[longint'(off) + i] = wd[8*i +: 8];
         end else begin
            e.data = ref_dword(longint'(off));
         end
      end
      if (is_mem) exp_mem.push_back(e); else exp_if.push_back(e);
      done = e.due;
   endtask

   // Monitor
   logic [1:0]  hold_if_resp = '0, hold_mem_resp = '0;
   logic [63:0] hold_if_data = '0, hold_mem_data = '0;

   always @(negedge clk) begin
      exp_t e;
      ram_t r;
      if (rst) begin
         hold_if_resp  = '0; hold_if_data  = '0;
         hold_mem_resp = '0; hold_mem_data = '0;
      end else begin
         if (if_ready && mem_ready) chk("both_ready", 64'd1, 64'd0);
         if (if_ready) begin
            if (exp_if.size() == 0) chk("if_unexpected_ready", 64'd1, 64'd0);
            else begin
               e = exp_if.pop_front();
               chk("if_ready_cycle", 64'(cyc), 64'(e.due));
               hold_if_resp = e.resp;
               hold_if_data = e.data;
            end
         end
         chk("if_resp", 64'(if_resp), 64'(hold_if_resp));
         chk("if_data_read", if_data_read, hold_if_data);
         if (mem_ready) begin
            if (exp_mem.size() == 0) chk("mem_unexpected_ready", 64'd1, 64'd0);
            else begin
               e = exp_mem.pop_front();
               chk("mem_ready_cycle", 64'(cyc), 64'(e.due));
               hold_mem_resp = e.resp;
               hold_mem_data = e.data;
            end
         end
         chk("mem_resp", 64'(mem_resp), 64'(hold_mem_resp));
         chk("mem_data_read", mem_data_read, hold_mem_data);
         if (ram_en) begin
            if (exp_ram.size() == 0) chk("ram_unexpected_en", 64'd1, 64'd0);
            else begin
               r = exp_ram.pop_front();
               chk("ram_en_cycle", 64'(cyc), 64'(r.due));
               chk("ram_we", 64'(ram_we), 64'(r.we));
               chk("ram_addr", 64'(ram_addr), r.addr);
               chk("ram_wstrb", 64'(ram_wstrb), 64'(r.strb));
               chk("ram_wdata", ram_wdata, r.wdata);
            end
         end
      end
   end

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_if_ready"}, 64'(if_ready), 64'd0);
      chk({tag, "_if_resp"}, 64'(if_resp), 64'd0);
      chk({tag, "_if_data"}, if_data_read, 64'd0);
      chk({tag, "_mem_ready"}, 64'(mem_ready), 64'd0);
      chk({tag, "_mem_resp"}, 64'(mem_resp), 64'd0);
      chk({tag, "_mem_data"}, mem_data_read, 64'd0);
      chk({tag, "_ram_en"}, 64'(ram_en), 64'd0);
      chk({tag, "_ram_we"}, 64'(ram_we), 64'd0);
      chk({tag, "_ram_addr"}, 64'(ram_addr), 64'd0);
      chk({tag, "_ram_wstrb"}, 64'(ram_wstrb), 64'd0);
      chk({tag, "_ram_wdata"}, ram_wdata, 64'd0);
   endtask

   // Issues up to one request per port in the same cycle and waits for both completions.
   task automatic txn(input bit use_if, input logic [63:0] ia, input logic [1:0] is,
                      input bit use_mem, input logic [1:0] rq, input logic [63:0] ma,
                      input logic [1:0] ms, input logic [63:0] wd);
      int t0, dm, di, n;
      @(posedge clk); #1;
      t0 = cyc;
      dm = t0 - 1;
      if (use_mem) begin
         mem_valid = 1'b1; mem_req = rq; mem_addr = ma; mem_size = ms; mem_data_write = wd;
         predict(1'b1, ma, ms, rq == 2'b01, wd, t0, dm);
      end
      if (use_if) begin
         if_valid = 1'b1; if_addr = ia; if_size = is;
         predict(1'b0, ia, is, 1'b0, 64'd0, use_mem ? dm + 1 : t0, di);
      end
      n = 0;
      while ((if_valid || mem_valid) && n < 40) begin
         @(negedge clk);
         if (if_ready)  if_valid  = 1'b0;
         if (mem_ready) mem_valid = 1'b0;
         n++;
      end
      if (if_valid || mem_valid) begin
         chk("ready_timeout", 64'd1, 64'd0);
         if_valid = 1'b0; mem_valid = 1'b0;
         exp_if.delete(); exp_mem.delete(); exp_ram.delete();
      end
   endtask

   function automatic logic [63:0] rnd_addr(input logic [1:0] sz);
      logic [63:0] a;
      int r = $urandom_range(0, 9);
      if (r == 0) a = {$urandom, $urandom};
      else if (r == 1) a = BASE + 64'(RSZ) - 64'd8 + 64'($urandom_range(0, 15));
      else a = BASE + 64'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << sz) - 1);
      return a;
   endfunction

   initial begin
      int t0, d;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;

      preload(1, 64'h1122_3344_5566_7788);
      txn(1, BASE + 64'h8, 2'b11, 0, 2'b00, 64'd0, 2'b00, 64'd0);
      txn(0, 64'd0, 2'b00, 1, 2'b01, BASE + 64'h5, 2'b00, 64'hAB);
      txn(1, BASE, 2'b11, 1, 2'b00, BASE, 2'b10, 64'd0);
      txn(0, 64'd0, 2'b00, 1, 2'b00, BASE + 64'h3, 2'b01, 64'd0);
      txn(1, 64'h1000, 2'b11, 0, 2'b00, 64'd0, 2'b00, 64'd0);
      txn(1, BASE + 64'(RSZ) - 64'd8, 2'b11, 0, 2'b00, 64'd0, 2'b00, 64'd0);
      txn(1, BASE + 64'(RSZ), 2'b11, 0, 2'b00, 64'd0, 2'b00, 64'd0);
      txn(0, 64'd0, 2'b00, 1, 2'b01, BASE - 64'd8, 2'b11, 64'h55);
      txn(0, 64'd0, 2'b00, 1, 2'b00, BASE + 64'(RSZ) + 64'd1, 2'b01, 64'd0);
      txn(1, BASE + 64'h10, 2'b11, 1, 2'b01, BASE + 64'h12, 2'b01, 64'hFFFF_FFFF_FFFF_BEEF);
      txn(0, 64'd0, 2'b00, 1, 2'b10, BASE + 64'h10, 2'b11, 64'd7);
      txn(1, BASE + 64'h3, 2'b00, 1, 2'b01, BASE + 64'h4, 2'b10, 64'hCAFE_F00D);

      // Reset lands in the last ACCESS cycle of a read, so its ready never appears.
      @(posedge clk); #1;
      t0 = cyc;
      if_valid = 1'b1; if_addr = BASE + 64'h18; if_size = 2'b11;
      predict(1'b0, if_addr, if_size, 1'b0, 64'd0, t0, d);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; if_valid = 1'b0;
      exp_if.delete();
      @(posedge clk); #1;
      check_outputs_zero("midreset");
      @(posedge clk); #1;
      rst = 1'b0;
      txn(1, BASE + 64'h18, 2'b11, 0, 2'b00, 64'd0, 2'b00, 64'd0);

      for (int i = 0; i < 300; i++) begin
         logic [1:0] is = 2'($urandom_range(0, 3));
         logic [1:0] ms = 2'($urandom_range(0, 3));
         int pick = $urandom_range(0, 2);
         txn(pick != 1, rnd_addr(is), is, pick != 0, 2'($urandom_range(0, 3)), rnd_addr(ms), ms,
             {$urandom, $urandom});
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (4) @(posedge clk);
      chk("if_queue_drained", 64'(exp_if.size()), 64'd0);
      chk("mem_queue_drained", 64'(exp_mem.size()), 64'd0);
      chk("ram_queue_drained", 64'(exp_ram.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
